// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line to memory-burst adaptor.
// Beat count and line offset are derived from the default line/beat widths.
package cacheline_adaptor_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;

  localparam int BEATS  = LINE_W / BURST_W;
  localparam int OFFSET = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } adaptor_state_t;

  typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bundle of cache-side request signals and memory-side burst signals.
// The slave view belongs to the adaptor; the master view belongs to its environment.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;

  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic [BURST_W-1:0] burst_o;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit cache-line read/write into a 4-beat 64-bit memory burst
// and returns a single completion pulse once the whole line has moved.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_WIDTH  = LINE_W,
  parameter int BURST_WIDTH = BURST_W,
  parameter int ADDR_WIDTH  = ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  cacheline_adaptor_if.slave  bus
);

  adaptor_state_t          r_state;
  adaptor_state_t          w_stateNext;
  beat_idx_t               r_count;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LINE_WIDTH-1:0]   r_wrLine;
  logic [LINE_WIDTH-1:0]   r_rdLine;

  logic                    w_readOut;
  logic                    w_writeOut;
  logic                    w_respOut;
  logic                    w_lastBeat;
  logic [BURST_WIDTH-1:0]  w_burstOut;

  assign w_lastBeat = bus.resp_i && (r_count == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Read has priority on a simultaneous request; the cache keeps holding the write.
  always_comb begin
    w_stateNext = r_state;
    w_readOut   = 1'b0;
    w_writeOut  = 1'b0;
    w_respOut   = 1'b0;
    w_burstOut  = '0;
    case (r_state)
      IDLE: begin
        if (bus.read_i) begin
          w_stateNext = READ;
        end else if (bus.write_i) begin
          w_stateNext = WRITE;
        end
      end
      READ: begin
        w_readOut = 1'b1;
        if (w_lastBeat) begin
          w_stateNext = DONE;
        end
      end
      WRITE: begin
        w_writeOut = 1'b1;
        w_burstOut = r_wrLine[int'(r_count) * BURST_WIDTH +: BURST_WIDTH];
        if (w_lastBeat) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_respOut   = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Count saturates on the last beat so it never wraps inside a transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_addr   <= '0;
      r_wrLine <= '0;
      r_rdLine <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.read_i || bus.write_i) begin
            r_addr  <= {bus.address_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
            r_count <= '0;
            if (!bus.read_i) begin
              r_wrLine <= bus.line_i;
            end
          end
        end
        READ: begin
          if (bus.resp_i) begin
            r_rdLine[int'(r_count) * BURST_WIDTH +: BURST_WIDTH] <= bus.burst_i;
            if (r_count != LAST_BEAT) begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i && (r_count != LAST_BEAT)) begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.read_o    = w_readOut;
  assign bus.write_o   = w_writeOut;
  assign bus.resp_o    = w_respOut;
  assign bus.burst_o   = w_burstOut;
  assign bus.address_o = r_addr;
  assign bus.line_o    = r_rdLine;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: a memory model answers bursts,
// a monitor pops expected completions and write beats as the DUT presents them.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  typedef struct {
    logic [255:0] line;
    logic [31:0]  addr;
  } exp_t;

  localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LINE_B = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'h0F0F_0F0F_0F0F_0F0F;
  localparam logic [63:0] D3 = 64'hA5A5_A5A5_5A5A_5A5A;
  localparam logic [63:0] E0 = 64'h1000_0000_0000_0001;
  localparam logic [63:0] E1 = 64'h2000_0000_0000_0002;
  localparam logic [63:0] E2 = 64'h3000_0000_0000_0003;
  localparam logic [63:0] E3 = 64'h4000_0000_0000_0004;

  logic clk = 1'b0;
  logic rst_n;

  exp_t        expQ[$];
  logic [63:0] beatQ[$];
  int          checks = 0;
  int          failures = 0;

  logic [255:0] memData = '0;
  int           memGap = 0;
  bit           spuriousResp = 1'b0;
  int           memBeat = 0;
  int           gapCnt = 0;
  logic         memResp = 1'b0;
  logic [63:0]  memBurst = '0;

  always #5 clk = ~clk;

  cacheline_adaptor_if bus();

  assign bus.resp_i  = memResp;
  assign bus.burst_i = memBurst;

  cacheline_adaptor #(
    .LINE_WIDTH (LINE_W),
    .BURST_WIDTH(BURST_W),
    .ADDR_WIDTH (ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [255:0] line);
    @(posedge clk);
    #1;
    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.address_i = addr;
    bus.line_i    = line;
  endtask

  task automatic waitResp(output int cycles, output int strobes);
    bit done;
    done    = 1'b0;
    cycles  = 0;
    strobes = 0;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if (bus.read_o || bus.write_o) strobes++;
      if (bus.resp_o) begin
        done = 1'b1;
      end else if (cycles >= 60) begin
        checks++;
        failures++;
        $display("[TB] FAIL resp_timeout actual=no resp_o expected=resp_o within 60 cycles");
        done = 1'b1;
      end
    end
  endtask

  task automatic finishTxn(input bit keepWrite);
    @(posedge clk);
    #1;
    bus.read_i = 1'b0;
    if (!keepWrite) bus.write_i = 1'b0;
    @(negedge clk);
    checkOutput("resp_one_cycle", 256'(bus.resp_o), 256'(0));
    checkOutput("idle_gap", 256'({bus.read_o, bus.write_o}), 256'(0));
  endtask

  // Memory responder: a beat every (memGap+1) cycles while a strobe is up.
  always @(posedge clk) begin
    #1;
    if (bus.read_o || bus.write_o) begin
      if (gapCnt == 0) begin
        memResp  = 1'b1;
        memBurst = memData[memBeat*64 +: 64];
        memBeat++;
        gapCnt = memGap;
      end else begin
        memResp = 1'b0;
        gapCnt--;
      end
    end else begin
      memResp  = spuriousResp;
      memBurst = 64'hBAD0_BAD0_BAD0_BAD0;
      memBeat  = 0;
      gapCnt   = 0;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [63:0] b;
    if (rst_n === 1'b1) begin
      if (bus.resp_o) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL resp_unexpected actual=1 expected=0");
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_line", bus.line_o, e.line);
          checkOutput("resp_addr", 256'(bus.address_o), 256'(e.addr));
        end
      end
      if (bus.write_o && bus.resp_i) begin
        if (beatQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL write_beat_unexpected actual=%0h expected=none", bus.burst_o);
        end else begin
          b = beatQ.pop_front();
          checkOutput("write_beat", 256'(bus.burst_o), 256'(b));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int stb;
    rst_n         = 1'b0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_read_o",    256'(bus.read_o), 256'(0));
    checkOutput("rst_write_o",   256'(bus.write_o), 256'(0));
    checkOutput("rst_resp_o",    256'(bus.resp_o), 256'(0));
    checkOutput("rst_address_o", 256'(bus.address_o), 256'(0));
    checkOutput("rst_burst_o",   256'(bus.burst_o), 256'(0));
    checkOutput("rst_line_o",    bus.line_o, 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] back-to-back read");
    memData = LINE_A;
    memGap  = 0;
    expQ.push_back('{LINE_A, 32'h0000_1A60});
    applyStimulus(1'b1, 1'b0, 32'h0000_1A7C, '0);
    waitResp(cyc, stb);
    checkOutput("read_latency", 256'(cyc), 256'(6));
    checkOutput("read_strobe_cycles", 256'(stb), 256'(4));
    finishTxn(1'b0);

    $display("[TB] write with address change mid-burst");
    expQ.push_back('{LINE_A, 32'h0000_1220});
    beatQ.push_back(D0);
    beatQ.push_back(D1);
    beatQ.push_back(D2);
    beatQ.push_back(D3);
    applyStimulus(1'b0, 1'b1, 32'h0000_1234, {D3, D2, D1, D0});
    @(posedge clk);
    #1;
    bus.address_i = 32'hDEAD_BEEF;
    waitResp(cyc, stb);
    checkOutput("write_strobe_cycles", 256'(stb), 256'(4));
    finishTxn(1'b0);

    $display("[TB] read with two-cycle beat gaps");
    memGap = 2;
    expQ.push_back('{LINE_A, 32'h0000_2000});
    applyStimulus(1'b1, 1'b0, 32'h0000_201F, '0);
    waitResp(cyc, stb);
    checkOutput("gap_read_latency", 256'(cyc), 256'(12));
    checkOutput("gap_read_strobe_cycles", 256'(stb), 256'(10));
    finishTxn(1'b0);
    memGap = 0;

    $display("[TB] reset after two read beats");
    memData = LINE_B;
    applyStimulus(1'b1, 1'b0, 32'h0000_5000, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b0;
    bus.read_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_read_o",    256'(bus.read_o), 256'(0));
    checkOutput("abort_resp_o",    256'(bus.resp_o), 256'(0));
    checkOutput("abort_address_o", 256'(bus.address_o), 256'(0));
    checkOutput("abort_line_o",    bus.line_o, 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 256'({bus.read_o, bus.resp_o}), 256'(0));
    end

    $display("[TB] read of a different line after reset");
    expQ.push_back('{LINE_B, 32'h0000_3040});
    applyStimulus(1'b1, 1'b0, 32'h0000_305F, '0);
    waitResp(cyc, stb);
    checkOutput("post_reset_latency", 256'(cyc), 256'(6));
    finishTxn(1'b0);

    $display("[TB] spurious resp_i while idle");
    spuriousResp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("spurious_idle", 256'({bus.read_o, bus.write_o, bus.resp_o}), 256'(0));
    end
    spuriousResp = 1'b0;
    checkOutput("spurious_line_hold", bus.line_o, LINE_B);
    checkOutput("spurious_addr_hold", 256'(bus.address_o), 256'(32'h0000_3040));

    $display("[TB] simultaneous read and write");
    memData = LINE_A;
    expQ.push_back('{LINE_A, 32'h0000_4000});
    expQ.push_back('{LINE_A, 32'h0000_4000});
    beatQ.push_back(E0);
    beatQ.push_back(E1);
    beatQ.push_back(E2);
    beatQ.push_back(E3);
    applyStimulus(1'b1, 1'b1, 32'h0000_4008, {E3, E2, E1, E0});
    waitResp(cyc, stb);
    checkOutput("simul_read_latency", 256'(cyc), 256'(6));
    finishTxn(1'b1);
    waitResp(cyc, stb);
    checkOutput("simul_write_latency", 256'(cyc), 256'(5));
    checkOutput("simul_write_strobe", 256'(stb), 256'(4));
    finishTxn(1'b0);

    repeat (3) @(negedge clk);
    checkOutput("queue_drain", 256'(expQ.size() + beatQ.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
